vector_feeder: RTL
==================

# vector_feeder

Read-side sequencer for the linear layer datapath. On `start`, it walks a feature RAM and a weight RAM in NP-lane chunks and streams matched feature/weight vectors to `vector_multiplier` under a valid/ready handshake. Sideband flags mark the first and last chunk of each output neuron so the downstream accumulator knows when to clear and when to emit a neuron result. It sits between the on-chip parameter/feature RAMs and the multiplier lanes.

## Interface
Parameters:
- `REG_DEPTH`, 8: bit width of one feature or weight element.
- `NP`, 1: number of lanes, i.e. elements per RAM word and per output vector.
- `IN_FEATURES`, 16: elements per input vector. Must be a multiple of NP. CHUNKS = IN_FEATURES/NP.
- `OUT_FEATURES`, 4: number of output neurons. Total transfers T = OUT_FEATURES*CHUNKS.

Ports:
- `clk`, in, 1: clock. All logic is clocked on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle request to begin a pass. Honoured only while `busy`=0.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: one-cycle pulse after the final transfer of a pass.
- `feat_en`, out, 1: feature RAM read enable.
- `feat_addr`, out, clog2(CHUNKS) (minimum 1): feature RAM word address.
- `feat_data`, in, NP*REG_DEPTH: feature RAM read data, valid 1 cycle after `feat_en`. The RAM holds its output while `feat_en`=0.
- `wgt_en`, out, 1: weight RAM read enable.
- `wgt_addr`, out, clog2(T) (minimum 1): weight RAM word address.
- `wgt_data`, in, NP*REG_DEPTH: weight RAM read data, same latency and hold rule as `feat_data`.
- `features_out`, out, [NP-1:0][REG_DEPTH-1:0]: equals `feat_data`, lane i = bits [i*REG_DEPTH +: REG_DEPTH].
- `weights_out`, out, [NP-1:0][REG_DEPTH-1:0]: equals `wgt_data`, same lane packing.
- `vec_valid`, out, 1: the output vector and its sidebands are valid.
- `vec_ready`, in, 1: the downstream stage accepts. A transfer occurs on any cycle with `vec_valid` and `vec_ready` both high.
- `vec_first`, out, 1: this chunk is chunk 0 of its neuron.
- `vec_last`, out, 1: this chunk is chunk CHUNKS-1 of its neuron.
- `neuron_idx`, out, clog2(OUT_FEATURES) (minimum 1): the neuron this chunk belongs to.

## Operation
States:
- IDLE
  - `busy`=0, no RAM enables.
  - `start`=1 → RUN. Chunk counter c=0, neuron counter n=0, weight address counter w=0.
- RUN
  - Define `adv` = ~`vec_valid` | `vec_ready`.
  - When `adv`=1: assert `feat_en` and `wgt_en` with `feat_addr`=c and `wgt_addr`=w, and register sidebands (first = c==0, last = c==CHUNKS-1, idx = n) into a one-deep stage that aligns them with the RAM data.
  - Then increment w, and increment c with wrap at CHUNKS; on each wrap, increment n.
  - After issuing c=CHUNKS-1 for n=OUT_FEATURES-1 → DRAIN.
  - When `adv`=0: enables stay low, and the counters, sidebands and `vec_valid` hold. The RAM data is therefore stable under backpressure.
- DRAIN
  - No new issues.
  - When the final vector transfers → DONE.
- DONE
  - `done`=1 and `busy`=1 for one cycle, then → IDLE.

Rules:
- `vec_valid` is set in the cycle after an issue.
- `vec_valid` is cleared after a transfer that has no concurrent issue.
- `start` is ignored while `busy`=1, including in the DONE cycle.
- Vectors are delivered in strict order: w = 0..T-1.
- Element data passes through unmodified. There is no arithmetic on data; counter widths are exactly as listed.
- CHUNKS=1: `vec_first` and `vec_last` are both 1 on every transfer.
- OUT_FEATURES=1: `neuron_idx` is constantly 0.

## Timing
- Reset: with `rst` asserted, all outputs are 0: `busy`, `done`, `feat_en`, `wgt_en`, addresses, `vec_valid`, `vec_first`, `vec_last`, `neuron_idx`. The state is IDLE and the counters are 0.
- Reset mid-pass: the pass is abandoned immediately, and no `done` pulse is produced.
- `start` sampled high in cycle 0:
  - `busy`=1 from cycle 1.
  - First issue in cycle 1.
  - First `vec_valid` in cycle 2.
- With `vec_ready` held at 1:
  - one transfer per cycle in cycles 2..T+1;
  - `done` in cycle T+2;
  - `busy`=0 in cycle T+3;
  - the earliest honoured new `start` is in cycle T+3.
- Each cycle with `vec_valid`=1 and `vec_ready`=0 extends everything after it by one cycle.
- `features_out` and `weights_out` are combinational from the RAM outputs. All other outputs are registered.

## Test plan
- **Nominal pass.** NP=1, IN=4, OUT=2; feature RAM={1,2,3,4}, weight RAM=0..7; `vec_ready`=1.
  - Required: 8 transfers.
  - `features_out` = 1,2,3,4,1,2,3,4; `weights_out` = 0..7.
  - `vec_first` high on transfers 0 and 4; `vec_last` high on transfers 3 and 7; `neuron_idx` = 0×4 then 1×4.
  - `done` in cycle 10.
- **Lane packing.** NP=4, IN=8, OUT=1.
  - Required: 2 transfers.
  - Lane i of transfer k equals element 4k+i.
  - First transfer: `vec_first`=1, `vec_last`=0. Second transfer: `vec_first`=0, `vec_last`=1.
- **Backpressure.** Nominal config; `vec_ready` low on cycles 3–5 and on cycle 7.
  - Required: data and sidebands are stable while stalled, with no dropped or duplicated vectors.
  - `done` in cycle 14.
- **Start while busy.** Pulse `start` in cycle 0, then again in cycles 4 and T+2.
  - Required: both later pulses are ignored, and exactly one pass of T transfers occurs.
- **Reset mid-pass.** Assert `rst` in cycle 5.
  - Required: all outputs are 0 immediately, and no `done` pulse.
  - A `start` after reset release yields a full correct pass starting from w=0.
- **Back-to-back passes.** Assert `start` in cycle T+3.
  - Required: the second pass is identical to the first, with `busy` low for exactly one cycle between the passes.

Source files
------------

// File: rtl/vector_feeder.sv
// Read-side sequencer: walks the feature and weight RAMs in NP-lane chunks and
// streams matched vectors, with first/last/neuron sidebands, over valid/ready.
module vector_feeder #(
    parameter int REG_DEPTH    = 8,
    parameter int NP           = 1,
    parameter int IN_FEATURES  = 16,
    parameter int OUT_FEATURES = 4,
    localparam int CHUNKS = IN_FEATURES / NP,
    localparam int TOTAL  = OUT_FEATURES * CHUNKS,
    localparam int FW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int WW     = (TOTAL > 1) ? $clog2(TOTAL) : 1,
    localparam int NW     = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              feat_en,
    output logic [FW-1:0]                     feat_addr,
    input  logic [NP*REG_DEPTH-1:0]           feat_data,
    output logic                              wgt_en,
    output logic [WW-1:0]                     wgt_addr,
    input  logic [NP*REG_DEPTH-1:0]           wgt_data,
    output logic [NP-1:0][REG_DEPTH-1:0]      features_out,
    output logic [NP-1:0][REG_DEPTH-1:0]      weights_out,
    output logic                              vec_valid,
    input  logic                              vec_ready,
    output logic                              vec_first,
    output logic                              vec_last,
    output logic [NW-1:0]                     neuron_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [FW-1:0] C_LAST = FW'(CHUNKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(OUT_FEATURES - 1);

    state_t        state, next_state;
    logic [FW-1:0] chunk;
    logic [NW-1:0] neuron;
    logic [WW-1:0] waddr;
    logic          adv, issue, last_issue, xfer;

    // A new read may be issued whenever the output stage is empty or draining.
    assign adv        = ~vec_valid | vec_ready;
    assign issue      = (state == S_RUN) & adv;
    assign last_issue = issue & (chunk == C_LAST) & (neuron == N_LAST);
    assign xfer       = vec_valid & vec_ready;

    assign feat_en      = issue;
    assign wgt_en       = issue;
    assign feat_addr    = chunk;
    assign wgt_addr     = waddr;
    assign features_out = feat_data;
    assign weights_out  = wgt_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start)      next_state = S_RUN;
            S_RUN:   if (last_issue) next_state = S_DRAIN;
            S_DRAIN: if (xfer)       next_state = S_DONE;
            S_DONE:                  next_state = S_IDLE;
            default:                 next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            chunk      <= '0;
            neuron     <= '0;
            waddr      <= '0;
            vec_valid  <= 1'b0;
            vec_first  <= 1'b0;
            vec_last   <= 1'b0;
            neuron_idx <= '0;
        end else begin
            busy <= (next_state != S_IDLE);
            done <= (next_state == S_DONE);

            if (state == S_IDLE && start) begin
                chunk  <= '0;
                neuron <= '0;
                waddr  <= '0;
            end else if (issue) begin
                waddr <= waddr + 1'b1;
                if (chunk == C_LAST) begin
                    chunk  <= '0;
                    neuron <= (neuron == N_LAST) ? '0 : neuron + 1'b1;
                end else begin
                    chunk <= chunk + 1'b1;
                end
                // Sidebands ride one cycle behind the address, matching RAM latency.
                vec_first  <= (chunk == '0);
                vec_last   <= (chunk == C_LAST);
                neuron_idx <= neuron;
            end

            if (issue)     vec_valid <= 1'b1;
            else if (xfer) vec_valid <= 1'b0;
        end
    end

endmodule
